// File: rtl/hazard_stall_ctrl.sv
// Hazard detection and stall sequencing for the 5-stage MIPS pipeline, including MULT/DIV occupancy tracking.
// Optional stall performance counter enabled by defining HAZARD_STALL_PERF_EN.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             id_is_md,
  input  logic             id_reads_hilo,
  input  logic             branch_taken,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_dst,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_dst,
  input  logic             md_start,
  input  logic             md_is_div,
  output logic             pc_write,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             md_busy,
  output logic [7:0]       md_remaining
`ifdef HAZARD_STALL_PERF_EN
  ,
  input  logic             perf_clr,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  // The counter is loaded with N-1: the cycle md_start is seen counts as the first occupancy cycle.
  localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES - 1);
  localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] remaining_nxt;

  logic ex_match;
  logic mem_match;
  logic lu;
  logic br_ex;
  logic br_mem;
  logic md_h;
  logic stall;

  // $0 is hardwired to zero, so a write to it can never create a dependency.
  assign ex_match  = (ex_dst != 5'd0) &&
                     ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));
  assign mem_match = (mem_dst != 5'd0) &&
                     ((mem_dst == id_rs) || (id_uses_rt && (mem_dst == id_rt)));

  assign lu     = ex_mem_read && ex_match;
  assign br_ex  = id_is_branch && ex_reg_write && ex_match;
  assign br_mem = id_is_branch && mem_mem_read && mem_match;
  assign md_h   = (state == MD_BUSY) && (id_is_md || id_reads_hilo);
  assign stall  = lu | br_ex | br_mem | md_h;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      md_remaining <= 8'd0;
    end else begin
      state        <= state_nxt;
      md_remaining <= remaining_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = md_remaining;
    case (state)
      RUN: begin
        if (md_start) begin
          state_nxt     = MD_BUSY;
          remaining_nxt = md_is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_BUSY: begin
        // md_start is ignored here; a second MULT/DIV is held in ID by md_h.
        if (md_remaining <= 8'd1) begin
          state_nxt     = RUN;
          remaining_nxt = 8'd0;
        end else begin
          remaining_nxt = md_remaining - 8'd1;
        end
      end
      default: begin
        state_nxt     = RUN;
        remaining_nxt = 8'd0;
      end
    endcase
  end

  assign md_busy = (state == MD_BUSY);

  // A stalled branch is never flushed: its compare operands are stale, so branch_taken is untrusted.
  always_comb begin
    pc_write     = 1'b1;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (reset) begin
      pc_write = 1'b0;
    end else if (stall) begin
      pc_write     = 1'b0;
      if_id_stall  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
    end
  end

`ifdef HAZARD_STALL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
`endif

  a_stall_flush_excl : assert property (@(posedge clk) disable iff (reset)
    !(if_id_stall && if_id_flush));

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed, table-driven bench for hazard_stall_ctrl with hand-computed expectations.
// Exercises the stall counter too when HAZARD_STALL_PERF_EN is defined.
module tb_hazard_stall_ctrl;

  localparam int MULT_CYCLES = 4;
  localparam int DIV_CYCLES  = 32;
  localparam int CNT_W       = 32;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       id_is_branch;
  logic       id_is_md;
  logic       id_reads_hilo;
  logic       branch_taken;
  logic       ex_reg_write;
  logic       ex_mem_read;
  logic [4:0] ex_dst;
  logic       mem_mem_read;
  logic [4:0] mem_dst;
  logic       md_start;
  logic       md_is_div;
  logic       pc_write;
  logic       if_id_stall;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic       md_busy;
  logic [7:0] md_remaining;
`ifdef HAZARD_STALL_PERF_EN
  logic             perf_clr;
  logic [CNT_W-1:0] stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Control outputs packed as {pc_write, if_id_stall, if_id_flush, id_ex_bubble}.
  localparam logic [3:0] C_RUN   = 4'b1000;
  localparam logic [3:0] C_STALL = 4'b0101;
  localparam logic [3:0] C_FLUSH = 4'b1010;
  localparam logic [3:0] C_RST   = 4'b0000;

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       is_branch;
    logic       is_md;
    logic       reads_hilo;
    logic       taken;
    logic       ex_rw;
    logic       ex_mr;
    logic [4:0] ex_d;
    logic       mem_mr;
    logic [4:0] mem_d;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[13];

  hazard_stall_ctrl #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_is_branch (id_is_branch),
    .id_is_md     (id_is_md),
    .id_reads_hilo(id_reads_hilo),
    .branch_taken (branch_taken),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_dst       (ex_dst),
    .mem_mem_read (mem_mem_read),
    .mem_dst      (mem_dst),
    .md_start     (md_start),
    .md_is_div    (md_is_div),
    .pc_write     (pc_write),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .md_busy      (md_busy),
    .md_remaining (md_remaining)
`ifdef HAZARD_STALL_PERF_EN
    ,
    .perf_clr     (perf_clr),
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_ctl(input string name, input logic [3:0] expected);
    check(name, {28'd0, pc_write, if_id_stall, if_id_flush, id_ex_bubble}, {28'd0, expected});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs         = 5'd0;
    id_rt         = 5'd0;
    id_uses_rt    = 1'b0;
    id_is_branch  = 1'b0;
    id_is_md      = 1'b0;
    id_reads_hilo = 1'b0;
    branch_taken  = 1'b0;
    ex_reg_write  = 1'b0;
    ex_mem_read   = 1'b0;
    ex_dst        = 5'd0;
    mem_mem_read  = 1'b0;
    mem_dst       = 5'd0;
    md_start      = 1'b0;
    md_is_div     = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    id_rs        = v.rs;
    id_rt        = v.rt;
    id_uses_rt   = v.uses_rt;
    id_is_branch = v.is_branch;
    id_is_md     = v.is_md;
    id_reads_hilo = v.reads_hilo;
    branch_taken = v.taken;
    ex_reg_write = v.ex_rw;
    ex_mem_read  = v.ex_mr;
    ex_dst       = v.ex_d;
    mem_mem_read = v.mem_mr;
    mem_dst      = v.mem_d;
  endtask

  initial begin
    //          name            rs     rt     urt   br    md    hilo  tkn   exrw  exmr  exd    mmr   md     exp
    vecs[0]  = '{"lu_rs8",      5'd8,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 5'd0,  C_STALL};
    vecs[1]  = '{"lu_r0",       5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  C_RUN};
    vecs[2]  = '{"lu_rt_unused",5'd1,  5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9,  1'b0, 5'd0,  C_RUN};
    vecs[3]  = '{"lu_rt_used",  5'd1,  5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9,  1'b0, 5'd0,  C_STALL};
    vecs[4]  = '{"br_ex_alu",   5'd4,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd4,  1'b0, 5'd0,  C_STALL};
    vecs[5]  = '{"br_taken",    5'd4,  5'd6,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5,  1'b0, 5'd0,  C_FLUSH};
    vecs[6]  = '{"br_mem_load", 5'd1,  5'd6,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd6,  C_STALL};
    vecs[7]  = '{"mem_ld_nobr", 5'd6,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd6,  C_RUN};
    vecs[8]  = '{"ex_alu_nobr", 5'd3,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3,  1'b0, 5'd0,  C_RUN};
    vecs[9]  = '{"br_mem_alu",  5'd1,  5'd6,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd6,  C_RUN};
    vecs[10] = '{"md_in_run",   5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  C_RUN};
    vecs[11] = '{"br_mem_r0",   5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 5'd0,  C_FLUSH};
    vecs[12] = '{"taken_nohaz", 5'd1,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7,  1'b0, 5'd0,  C_FLUSH};

    clear_inputs();
`ifdef HAZARD_STALL_PERF_EN
    perf_clr = 1'b0;
`endif

    // Reset forces all controls low even with a load-use hazard present.
    reset       = 1'b1;
    ex_mem_read = 1'b1;
    ex_reg_write = 1'b1;
    ex_dst      = 5'd8;
    id_rs       = 5'd8;
    #3;
    check_ctl("reset_ctl", C_RST);
    check("reset_busy", {31'd0, md_busy}, 32'd0);
    check("reset_rem", {24'd0, md_remaining}, 32'd0);
    tick();
    reset = 1'b0;
    clear_inputs();
    tick();

    foreach (vecs[i]) begin
      apply_vec(vecs[i]);
      @(negedge clk);
      check_ctl(vecs[i].name, vecs[i].exp);
      tick();
    end
    clear_inputs();
    tick();

    // Load-use: stall one cycle, then the load sits in MEM and the add proceeds.
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd8; id_rs = 5'd8;
    @(negedge clk); check_ctl("lu_seq_c1", C_STALL);
    tick();
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dst = 5'd0;
    mem_mem_read = 1'b1; mem_dst = 5'd8;
    @(negedge clk); check_ctl("lu_seq_c2", C_RUN);
    tick();
    clear_inputs();

    // Branch after load: br_ex, then br_mem, then taken branch flushes.
    id_is_branch = 1'b1; id_rt = 5'd9; id_uses_rt = 1'b1; id_rs = 5'd2; branch_taken = 1'b1;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd9;
    @(negedge clk); check_ctl("brld_c1", C_STALL);
    tick();
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dst = 5'd0;
    mem_mem_read = 1'b1; mem_dst = 5'd9;
    @(negedge clk); check_ctl("brld_c2", C_STALL);
    tick();
    mem_mem_read = 1'b0; mem_dst = 5'd0;
    @(negedge clk); check_ctl("brld_c3", C_FLUSH);
    tick();
    clear_inputs();

    // Branch after ALU op: one stall, then resolves (not taken) with operand forwarded from MEM.
    id_is_branch = 1'b1; id_rs = 5'd4; ex_reg_write = 1'b1; ex_dst = 5'd4;
    @(negedge clk); check_ctl("bralu_c1", C_STALL);
    tick();
    ex_reg_write = 1'b0; ex_dst = 5'd0; mem_dst = 5'd4;
    @(negedge clk); check_ctl("bralu_c2", C_RUN);
    tick();
    clear_inputs();

    // DIV then MFLO: MFLO already in ID on the start cycle must not stall yet.
    md_start = 1'b1; md_is_div = 1'b1; id_reads_hilo = 1'b1;
    @(negedge clk);
    check_ctl("div_c0", C_RUN);
    check("div_c0_busy", {31'd0, md_busy}, 32'd0);
    tick();
    md_start = 1'b0; md_is_div = 1'b0;
    for (int k = 1; k < DIV_CYCLES; k++) begin
      md_start = (k == 5);  // illegal second start must be ignored
      @(negedge clk);
      check("div_rem", {24'd0, md_remaining}, 32'(DIV_CYCLES - k));
      check("div_busy", {31'd0, md_busy}, 32'd1);
      check_ctl("div_stall", C_STALL);
      tick();
    end
    md_start = 1'b0;
    @(negedge clk);
    check_ctl("div_release", C_RUN);
    check("div_rel_busy", {31'd0, md_busy}, 32'd0);
    check("div_rel_rem", {24'd0, md_remaining}, 32'd0);
    tick();
    clear_inputs();

    // Full MULT with a following MULT held in ID.
    md_start = 1'b1;
    tick();
    md_start = 1'b0; id_is_md = 1'b1;
    for (int k = 1; k < MULT_CYCLES; k++) begin
      @(negedge clk);
      check("mult_rem", {24'd0, md_remaining}, 32'(MULT_CYCLES - k));
      check_ctl("mult_stall", C_STALL);
      tick();
    end
    @(negedge clk);
    check_ctl("mult_release", C_RUN);
    check("mult_rel_busy", {31'd0, md_busy}, 32'd0);
    tick();
    clear_inputs();

    // Reset two cycles into a MULT aborts it.
    md_start = 1'b1;
    tick();
    md_start = 1'b0;
    @(negedge clk); check("rmult_rem1", {24'd0, md_remaining}, 32'd3);
    tick();
    @(negedge clk); check("rmult_rem2", {24'd0, md_remaining}, 32'd2);
    #2;
    reset = 1'b1;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd8; id_rs = 5'd8;
    #1;
    check_ctl("rmult_in_reset", C_RST);
    check("rmult_busy", {31'd0, md_busy}, 32'd0);
    check("rmult_rem", {24'd0, md_remaining}, 32'd0);
    tick();
    reset = 1'b0;
    clear_inputs();
    id_is_md = 1'b1;
    @(negedge clk);
    check_ctl("rmult_after", C_RUN);
    check("rmult_after_busy", {31'd0, md_busy}, 32'd0);
    tick();
    clear_inputs();

`ifdef HAZARD_STALL_PERF_EN
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    @(negedge clk); check("perf_cleared", stall_cycles, 32'd0);
    for (int i = 0; i < 3; i++) begin
      ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd8; id_rs = 5'd8;
      tick();
      clear_inputs();
      tick();
    end
    @(negedge clk); check("perf_lu3", stall_cycles, 32'd3);
    md_start = 1'b1; md_is_div = 1'b1;
    tick();
    md_start = 1'b0; md_is_div = 1'b0; id_reads_hilo = 1'b1;
    for (int k = 1; k <= DIV_CYCLES; k++) tick();
    clear_inputs();
    @(negedge clk); check("perf_total", stall_cycles, 32'd34);
    perf_clr = 1'b1;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd8; id_rs = 5'd8;
    tick();
    perf_clr = 1'b0;
    clear_inputs();
    @(negedge clk); check("perf_clr_prio", stall_cycles, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard and stall sequencer for the 5-stage MIPS core. It drives the IF/ID register's stall and flush controls, the PC write enable and the ID/EX bubble insertion. It detects load-use and branch-operand hazards, handles taken-branch flushes, and tracks multi-cycle MULT/DIV occupancy with an internal FSM and counter so that HI/LO consumers are held in ID until the result is ready.

Parameters:
MULT_CYCLES, 4, total EX occupancy of MULT/MULTU in cycles (range 2..255)
DIV_CYCLES, 32, total EX occupancy of DIV/DIVU in cycles (range 2..255)
CNT_W, 32, width of the stall performance counter (optional feature only)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high
id_rs  input  5  rs field of the instruction in ID
id_rt  input  5  rt field of the instruction in ID
id_uses_rt  input  1  ID instruction reads rt as a source
id_is_branch  input  1  ID instruction is BEQ/BNE (compare is done in ID)
id_is_md  input  1  ID instruction is MULT/MULTU/DIV/DIVU
id_reads_hilo  input  1  ID instruction is MFHI/MFLO
branch_taken  input  1  ID branch resolved taken this cycle
ex_reg_write  input  1  EX instruction writes the register file
ex_mem_read  input  1  EX instruction is a load
ex_dst  input  5  EX destination register
mem_mem_read  input  1  MEM instruction is a load
mem_dst  input  5  MEM destination register
md_start  input  1  MULT/DIV enters EX this cycle
md_is_div  input  1  qualifies md_start: 1 = divide, 0 = multiply
pc_write  output  1  PC update enable
if_id_stall  output  1  hold IF/ID contents
if_id_flush  output  1  zero IF/ID contents (NOP)
id_ex_bubble  output  1  inject NOP into ID/EX
md_busy  output  1  MULT/DIV unit occupied
md_remaining  output  8  cycles left in current MULT/DIV op

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk. While reset is high, the outputs are forced to: pc_write=0, if_id_stall=0, if_id_flush=0, id_ex_bubble=0, md_busy=0, md_remaining=0. The FSM goes to RUN.
- Hazard terms (combinational from inputs and current state); match(d) = d!=0 && (d==id_rs || (id_uses_rt && d==id_rt)):
  - lu = ex_mem_read && match(ex_dst)
  - br_ex = id_is_branch && ex_reg_write && match(ex_dst)
  - br_mem = id_is_branch && mem_mem_read && match(mem_dst)
  - md_h = (state==MD_BUSY) && (id_is_md || id_reads_hilo)
- stall = lu | br_ex | br_mem | md_h.
- When stall=1: pc_write=0, if_id_stall=1, id_ex_bubble=1, if_id_flush=0. branch_taken is ignored because the compare operands are stale.
- When stall=0 and branch_taken=1: if_id_flush=1, pc_write=1, if_id_stall=0, id_ex_bubble=0.
- Otherwise: pc_write=1, all other controls 0.
- Invariant: if_id_stall and if_id_flush are never high together.
- Register $0 never causes a hazard.
- FSM states RUN and MD_BUSY:
  - RUN & md_start: md_remaining <= (md_is_div ? DIV_CYCLES : MULT_CYCLES) - 1; go to MD_BUSY.
  - MD_BUSY: md_remaining decrements each cycle. When md_remaining==1, the next state is RUN with md_remaining=0.
  - md_busy = (state==MD_BUSY).
  - md_start while in MD_BUSY is ignored; it cannot occur legally because md_h stalls it.
- Latency:
  - md_h is first asserted the cycle after md_start.
  - The dependent instruction leaves ID in the first cycle with state==RUN, i.e. N cycles after md_start.
- A load-use stall lasts 1 cycle. A branch after a load stalls 2 cycles (br_ex, then br_mem). A branch after an ALU op stalls 1 cycle.
- Reset mid-MULT/DIV aborts the op: state=RUN, md_remaining=0.

Optional Feature:
Macro HAZARD_STALL_PERF_EN.
- Defined: adds input perf_clr (1 bit) and output stall_cycles (CNT_W bits).
  - stall_cycles increments on each cycle with stall=1 and saturates at all-ones.
  - perf_clr=1 synchronously clears it; clear takes priority over increment.
  - reset clears it to 0.
- Undefined: these ports and the counter are absent. Behaviour is otherwise identical.

Test Plan:
- Load-use: EX lw ex_dst=8, ID add id_rs=8 -> pc_write=0, if_id_stall=1, id_ex_bubble=1 for exactly 1 cycle; same with ex_dst=0 -> no stall.
- Branch after load: lw $9 in EX then MEM, ID beq id_rt=9, id_uses_rt=1, branch_taken=1 throughout -> 2 stall cycles with if_id_flush=0; 3rd cycle if_id_flush=1, pc_write=1.
- Branch after ALU: ex_reg_write=1, ex_dst=4, ID bne id_rs=4 -> 1 stall cycle, then resolves normally.
- DIV then MFLO: md_start=1, md_is_div=1 (DIV_CYCLES=32), next cycle id_reads_hilo=1 -> md_remaining=31 down to 1, stall held 31 cycles, released on cycle 32 with md_busy=0.
- Reset mid-MULT: md_start, 2 cycles later reset pulse -> md_busy=0, md_remaining=0, pc_write=0 during reset; pc_write=1 after release.
- HAZARD_STALL_PERF_EN: 3 load-use stalls plus one 31-cycle DIV stall -> stall_cycles=34; perf_clr=1 concurrent with a stall -> 0.
